dram_op_scheduler: RTL and testbench
====================================

Name: dram_op_scheduler

Overview:
- Arbitrates write and read requests from two host-side requesters onto the single-issue 16-core DRAM write/read engine.
- Drives the engine's IO_EN / IO_MODEL / WT_address / RD_address command inputs and waits for WT_DONE / RD_DONE.
- Enforces a recovery gap between operations and a completion timeout.
- Sits between the host/test logic and the DRAM top-level engine, on the engine's clock domain.

Parameters:
- GAP_CYCLES, 4: idle cycles inserted after each operation completes before the next issue; legal range 1..255.
- TIMEOUT_CYCLES, 4096: maximum cycles in WAIT_DONE before abort; legal range 2..65535.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_req  in  1  write requester asks for a write; held high until wr_ack.
- wr_addr  in  6  write row address; stable while wr_req is high.
- wr_ack  out  1  one-cycle pulse; write granted, wr_addr captured.
- rd_req  in  1  read requester asks for a read; held high until rd_ack.
- rd_addr  in  8  read address; stable while rd_req is high.
- rd_ack  out  1  one-cycle pulse; read granted, rd_addr captured.
- IO_EN  out  1  engine start strobe.
- IO_MODEL  out  2  engine mode: 01 = write, 10 = read, 00 = idle.
- WT_address  out  6  registered write address to the engine.
- RD_address  out  8  registered read address to the engine.
- WT_DONE  in  1  engine write-complete, level.
- RD_DONE  in  1  engine read-complete, level.
- op_done  out  1  one-cycle pulse; current operation completed normally.
- op_fail  out  1  one-cycle pulse; current operation aborted by timeout.
- op_is_rd  out  1  type of the last granted operation (1 = read); valid with op_done / op_fail.
- busy  out  1  high in every state except IDLE.
- err_timeout  out  1  sticky timeout flag.
- err_clr  in  1  clears err_timeout.

Behaviour:
- Reset values: all outputs 0; state IDLE; last-grant register = read, so a write wins the first tie.
- FSM states: IDLE, ISSUE, WAIT_DONE, GAP.
- IDLE:
  - If any request is pending, grant one. Both pending: round-robin against the last grant. One pending: grant it.
  - Grant cycle: pulse the matching ack, capture the address into WT_address or RD_address (the other address holds its value), set op_is_rd, go to ISSUE.
- ISSUE:
  - IO_EN = 1 for exactly one cycle.
  - IO_MODEL = 01 or 10 per the granted op, held from ISSUE through WAIT_DONE.
  - Go to WAIT_DONE; the timeout counter clears to 0.
- WAIT_DONE:
  - Only the done signal matching the op type counts (WT_DONE for a write, RD_DONE for a read). The other one is ignored.
  - Matching done high: pulse op_done, go to GAP.
  - Otherwise the counter increments. On reaching TIMEOUT_CYCLES-1 without done: pulse op_fail, set err_timeout, go to GAP.
  - Done on the same cycle as the timeout: completion wins, no error.
- GAP:
  - IO_MODEL = 00. The gap counter counts GAP_CYCLES.
  - Return to IDLE only once the counter has expired AND both WT_DONE and RD_DONE are low. The engine holding done high extends the gap indefinitely.
- Latency: request seen in IDLE at cycle N → ack at N, IO_EN at N+1. Minimum back-to-back issue spacing is 3 + GAP_CYCLES cycles plus the engine time.
- Requests arriving while busy wait; nothing is dropped. A requester dropping req before ack is legal: the request is withdrawn with no grant.
- err_timeout: set has priority over err_clr when both occur in the same cycle; otherwise err_clr clears it.
- Reset asserted mid-operation: immediate return to IDLE with all outputs 0, no op_done or op_fail. Any outstanding engine operation is abandoned.
- Counter widths: the timeout counter is 16 bits and the gap counter is 8 bits; neither wraps, both saturate at terminal count.

Test Plan:
- Single write: wr_req with wr_addr = 6'h2A; WT_DONE high 10 cycles after IO_EN → wr_ack in the request cycle; IO_EN one cycle later with IO_MODEL = 01 and WT_address = 2A; op_done with op_is_rd = 0; busy low exactly 4 cycles after WT_DONE falls (GAP_CYCLES = 4).
- Simultaneous wr_req and rd_req held for three rounds → grant order write, read, write. RD_address = rd_addr on the read ack. No second IO_EN before the GAP expires.
- Wrong done: read in flight with WT_DONE pulsed → ignored; completes only on RD_DONE; op_is_rd = 1.
- Timeout with TIMEOUT_CYCLES = 8 and no done → op_fail exactly 8 cycles after entering WAIT_DONE; err_timeout = 1 until err_clr; err_clr and a new timeout in the same cycle leave it at 1.
- Done held high for 20 cycles past GAP_CYCLES → stays in GAP with no grant; grants on the cycle after done falls.
- rst_n low during WAIT_DONE → asynchronous clear: IO_MODEL = 00, busy = 0, no op_done. After release, a pending rd_req is granted first (last-grant register reset to read, so a write would win a tie).

Source files
------------

// File: rtl/dram_op_scheduler.sv
// ============================================================================
// Module   : dram_op_scheduler
// Purpose  : Round-robin write/read arbiter driving a single-issue DRAM engine,
//            with a post-operation recovery gap and a completion timeout.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dram_op_scheduler #(
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_req,
    input  logic [5:0] wr_addr,
    output logic       wr_ack,
    input  logic       rd_req,
    input  logic [7:0] rd_addr,
    output logic       rd_ack,
    output logic       IO_EN,
    output logic [1:0] IO_MODEL,
    output logic [5:0] WT_address,
    output logic [7:0] RD_address,
    input  logic       WT_DONE,
    input  logic       RD_DONE,
    output logic       op_done,
    output logic       op_fail,
    output logic       op_is_rd,
    output logic       busy,
    output logic       err_timeout,
    input  logic       err_clr
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    localparam logic [15:0] C_TO_LAST  = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]  C_GAP_LAST = 8'(GAP_CYCLES - 1);

    state_t      state_q, state_d;
    logic        last_rd_q, last_rd_d;
    logic        op_rd_q, op_rd_d;
    logic [5:0]  wt_addr_q, wt_addr_d;
    logic [7:0]  rd_addr_q, rd_addr_d;
    logic [15:0] to_cnt_q, to_cnt_d;
    logic [7:0]  gap_cnt_q, gap_cnt_d;
    logic        err_q, err_d;

    logic        w_grant_wr;
    logic        w_grant_rd;
    logic        w_done_match;
    logic [1:0]  w_model;

    // Acks are gated by rst_n so nothing is granted while reset is held.
    assign w_grant_wr   = rst_n && wr_req && (!rd_req || last_rd_q);
    assign w_grant_rd   = rst_n && rd_req && !w_grant_wr;
    assign w_done_match = op_rd_q ? RD_DONE : WT_DONE;
    assign w_model      = op_rd_q ? 2'b10 : 2'b01;

    always_comb begin
        state_d   = state_q;
        last_rd_d = last_rd_q;
        op_rd_d   = op_rd_q;
        wt_addr_d = wt_addr_q;
        rd_addr_d = rd_addr_q;
        to_cnt_d  = to_cnt_q;
        gap_cnt_d = gap_cnt_q;
        err_d     = err_clr ? 1'b0 : err_q;
        wr_ack    = 1'b0;
        rd_ack    = 1'b0;
        IO_EN     = 1'b0;
        IO_MODEL  = 2'b00;
        op_done   = 1'b0;
        op_fail   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_grant_wr) begin
                    wr_ack    = 1'b1;
                    wt_addr_d = wr_addr;
                    op_rd_d   = 1'b0;
                    last_rd_d = 1'b0;
                    state_d   = ST_ISSUE;
                end else if (w_grant_rd) begin
                    rd_ack    = 1'b1;
                    rd_addr_d = rd_addr;
                    op_rd_d   = 1'b1;
                    last_rd_d = 1'b1;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                IO_EN    = 1'b1;
                IO_MODEL = w_model;
                to_cnt_d = 16'd0;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                IO_MODEL = w_model;
                // Completion is checked first so a done on the terminal cycle wins.
                if (w_done_match) begin
                    op_done   = 1'b1;
                    gap_cnt_d = 8'd0;
                    state_d   = ST_GAP;
                end else if (to_cnt_q == C_TO_LAST) begin
                    op_fail   = 1'b1;
                    err_d     = 1'b1;
                    gap_cnt_d = 8'd0;
                    state_d   = ST_GAP;
                end else begin
                    to_cnt_d = to_cnt_q + 16'd1;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q != C_GAP_LAST) begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                end else if (!WT_DONE && !RD_DONE) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            last_rd_q <= 1'b1;
            op_rd_q   <= 1'b0;
            wt_addr_q <= 6'd0;
            rd_addr_q <= 8'd0;
            to_cnt_q  <= 16'd0;
            gap_cnt_q <= 8'd0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_rd_q <= last_rd_d;
            op_rd_q   <= op_rd_d;
            wt_addr_q <= wt_addr_d;
            rd_addr_q <= rd_addr_d;
            to_cnt_q  <= to_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            err_q     <= err_d;
        end
    end

    assign WT_address  = wt_addr_q;
    assign RD_address  = rd_addr_q;
    assign op_is_rd    = op_rd_q;
    assign busy        = (state_q != ST_IDLE);
    assign err_timeout = err_q;

endmodule

`default_nettype wire

// File: tb/tb_dram_op_scheduler.sv
// ============================================================================
// Module   : tb_dram_op_scheduler
// Purpose  : Directed, self-checking bench for dram_op_scheduler.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dram_op_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, wr_req, rd_req, WT_DONE, RD_DONE, err_clr;
    logic [5:0] wr_addr;
    logic [7:0] rd_addr;

    logic       wr_ack, rd_ack, IO_EN, op_done, op_fail, op_is_rd, busy, err_timeout;
    logic [1:0] IO_MODEL;
    logic [5:0] WT_address;
    logic [7:0] RD_address;

    logic       t_wr_ack, t_rd_ack, t_IO_EN, t_op_done, t_op_fail, t_op_is_rd, t_busy, t_err_timeout;
    logic [1:0] t_IO_MODEL;
    logic [5:0] t_WT_address;
    logic [7:0] t_RD_address;

    dram_op_scheduler #(.GAP_CYCLES(4), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_ack(wr_ack),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
        .IO_EN(IO_EN), .IO_MODEL(IO_MODEL), .WT_address(WT_address), .RD_address(RD_address),
        .WT_DONE(WT_DONE), .RD_DONE(RD_DONE),
        .op_done(op_done), .op_fail(op_fail), .op_is_rd(op_is_rd), .busy(busy),
        .err_timeout(err_timeout), .err_clr(err_clr)
    );

    dram_op_scheduler #(.GAP_CYCLES(4), .TIMEOUT_CYCLES(8)) dut_to (
        .clk(clk), .rst_n(rst_n),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_ack(t_wr_ack),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(t_rd_ack),
        .IO_EN(t_IO_EN), .IO_MODEL(t_IO_MODEL), .WT_address(t_WT_address), .RD_address(t_RD_address),
        .WT_DONE(WT_DONE), .RD_DONE(RD_DONE),
        .op_done(t_op_done), .op_fail(t_op_fail), .op_is_rd(t_op_is_rd), .busy(t_busy),
        .err_timeout(t_err_timeout), .err_clr(err_clr)
    );

    typedef struct {
        logic       is_rd;
        logic [7:0] addr;
        int         dly;    // cycles after IO_EN at which the matching done pulses
        int         wrong;  // cycle at which the non-matching done pulses (0 = never)
        logic [1:0] model;
        int         gap;    // cycles from done falling to busy low
    } vec_t;

    vec_t tbl[6];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        nxt();
        nxt();
        rst_n = 1'b1;
    endtask

    initial begin
        int   k, gl, last_en, bad, early_en;
        logic found;

        tbl[0] = '{1'b0, 8'h2A, 10, 0, 2'b01, 4};
        tbl[1] = '{1'b1, 8'hA5,  3, 2, 2'b10, 4};
        tbl[2] = '{1'b0, 8'h3F,  1, 0, 2'b01, 4};
        tbl[3] = '{1'b0, 8'h15,  4, 1, 2'b01, 4};
        tbl[4] = '{1'b1, 8'h00,  5, 0, 2'b10, 4};
        tbl[5] = '{1'b1, 8'hFF, 16, 0, 2'b10, 4};

        rst_n = 1'b0; wr_req = 1'b1; rd_req = 1'b0; WT_DONE = 1'b0; RD_DONE = 1'b0;
        err_clr = 1'b0; wr_addr = 6'h00; rd_addr = 8'h00;
        smp();
        chk("rst_outputs", {wr_ack, rd_ack, IO_EN, IO_MODEL, WT_address, RD_address,
                            op_done, op_fail, op_is_rd, busy, err_timeout}, 0);
        chk("rst_outputs_t", {t_wr_ack, t_rd_ack, t_IO_EN, t_IO_MODEL, t_WT_address, t_RD_address,
                              t_op_done, t_op_fail, t_op_is_rd, t_busy, t_err_timeout}, 0);
        wr_req = 1'b0;
        nxt();
        rst_n = 1'b1;

        // Timeout path on the TIMEOUT_CYCLES=8 instance.
        rd_req = 1'b1; rd_addr = 8'h5C;
        smp();
        chk("to_ack", t_rd_ack, 1);
        nxt(); rd_req = 1'b0;
        smp();
        chk("to_issue", {t_IO_EN, t_IO_MODEL}, 3'b110);
        k = 0;
        for (int i = 1; i <= 20; i++) begin
            nxt(); smp();
            if (t_op_fail) begin k = i; break; end
        end
        chk("to_latency", k, 8);
        chk("to_no_done", t_op_done, 0);
        nxt(); smp();
        chk("to_err_set", {t_err_timeout, t_busy}, 2'b11);
        for (int i = 0; i < 20; i++) begin
            if (!t_busy) break;
            nxt(); smp();
        end
        chk("to_idle", t_busy, 0);
        nxt(); rd_req = 1'b1;
        smp();
        chk("to2_ack", t_rd_ack, 1);
        nxt(); rd_req = 1'b0;
        smp();
        for (int i = 1; i <= 8; i++) begin
            nxt(); err_clr = (i == 8);
            smp();
        end
        chk("to2_fail", t_op_fail, 1);
        nxt(); err_clr = 1'b0;
        smp();
        chk("to_set_over_clr", t_err_timeout, 1);
        nxt(); err_clr = 1'b1;
        smp();
        nxt(); err_clr = 1'b0;
        smp();
        chk("to_clr", t_err_timeout, 0);

        // Table-driven single transactions on the TIMEOUT_CYCLES=16 instance.
        nxt();
        do_reset();
        smp();
        foreach (tbl[n]) begin
            nxt();
            if (tbl[n].is_rd) begin rd_req = 1'b1; rd_addr = tbl[n].addr; end
            else begin wr_req = 1'b1; wr_addr = tbl[n].addr[5:0]; end
            smp();
            chk("ack", {wr_ack, rd_ack, busy}, tbl[n].is_rd ? 3'b010 : 3'b100);
            nxt(); wr_req = 1'b0; rd_req = 1'b0;
            smp();
            chk("issue", {IO_EN, IO_MODEL}, {1'b1, tbl[n].model});
            chk("addr", tbl[n].is_rd ? RD_address : {2'b00, WT_address},
                tbl[n].is_rd ? tbl[n].addr : {2'b00, tbl[n].addr[5:0]});
            for (int j = 1; j <= tbl[n].dly; j++) begin
                nxt();
                WT_DONE = tbl[n].is_rd ? (j == tbl[n].wrong) : (j == tbl[n].dly);
                RD_DONE = tbl[n].is_rd ? (j == tbl[n].dly) : (j == tbl[n].wrong);
                smp();
                if (j == tbl[n].wrong) chk("wrong_done_ignored", {op_done, IO_MODEL}, {1'b0, tbl[n].model});
            end
            chk("done", {op_done, op_fail, op_is_rd}, {1'b1, 1'b0, tbl[n].is_rd});
            nxt(); WT_DONE = 1'b0; RD_DONE = 1'b0;
            gl = 99;
            for (int g = 0; g < 20; g++) begin
                smp();
                if (!busy) begin gl = g; break; end
                nxt();
            end
            chk("gap_len", gl, tbl[n].gap);
        end
        chk("no_err_on_tie", err_timeout, 0);

        // Round robin with both requests held; last grant above was a read.
        nxt();
        wr_req = 1'b1; rd_req = 1'b1; wr_addr = 6'h11; rd_addr = 8'hC3;
        last_en = 0; early_en = 0;
        for (int r = 0; r < 3; r++) begin
            found = 1'b0;
            for (int i = 0; i < 30; i++) begin
                smp();
                if (wr_ack || rd_ack) begin found = 1'b1; break; end
                if (IO_EN) early_en++;
                nxt();
            end
            chk("rr_grant", {found, wr_ack, rd_ack}, {1'b1, r != 1, r == 1});
            nxt(); smp();
            chk("rr_issue", IO_EN, 1);
            if (r > 0) chk("rr_spacing", cyc - last_en, 8);
            last_en = cyc;
            if (r == 1) chk("rr_rd_addr", RD_address, 8'hC3);
            nxt();
            if (r == 2) begin wr_req = 1'b0; rd_req = 1'b0; end
            smp();
            nxt();
            if (r == 1) RD_DONE = 1'b1; else WT_DONE = 1'b1;
            smp();
            chk("rr_done", op_done, 1);
            nxt(); WT_DONE = 1'b0; RD_DONE = 1'b0;
        end
        chk("rr_no_early_en", early_en, 0);
        for (int i = 0; i < 20; i++) begin
            smp();
            if (!busy) break;
            nxt();
        end

        // Engine holding done high stretches the gap.
        nxt(); wr_req = 1'b1; wr_addr = 6'h07;
        smp();
        chk("held_ack", wr_ack, 1);
        nxt(); wr_req = 1'b0; rd_req = 1'b1; rd_addr = 8'h99;
        smp();
        nxt(); smp();
        nxt(); WT_DONE = 1'b1;
        smp();
        chk("held_done", op_done, 1);
        bad = 0;
        for (int i = 0; i < 24; i++) begin
            nxt(); smp();
            if (rd_ack || !busy) bad++;
        end
        chk("held_in_gap", bad, 0);
        nxt(); WT_DONE = 1'b0;
        smp();
        chk("held_fall_no_grant", rd_ack, 0);
        nxt(); smp();
        chk("held_grant_after_fall", rd_ack, 1);

        // Asynchronous reset during WAIT_DONE of that read.
        nxt(); rd_req = 1'b0;
        smp();
        nxt(); smp();
        chk("wait_model", IO_MODEL, 2'b10);
        nxt();
        #2 rst_n = 1'b0; RD_DONE = 1'b1; rd_req = 1'b1; rd_addr = 8'h42;
        #1;
        chk("rst_async", {op_done, op_fail, IO_MODEL, busy, rd_ack}, 0);
        RD_DONE = 1'b0;
        nxt(); rst_n = 1'b1;
        smp();
        chk("rst_rd_granted", rd_ack, 1);
        nxt(); rd_req = 1'b0;
        smp();
        chk("rst_rd_addr", RD_address, 8'h42);

        // Reset after a write grant restores the read-last priority.
        nxt(); rst_n = 1'b0;
        nxt(); rst_n = 1'b1; wr_req = 1'b1; wr_addr = 6'h01;
        smp();
        chk("rst2_wr_ack", wr_ack, 1);
        nxt(); wr_req = 1'b0;
        smp();
        nxt(); smp();
        nxt(); rst_n = 1'b0;
        nxt(); rst_n = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
        smp();
        chk("rst_tie_write", {wr_ack, rd_ack}, 2'b10);
        nxt(); wr_req = 1'b0; rd_req = 1'b0;
        smp();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
